// File: rtl/light_hash_pkg.sv
// light_hash_pkg: shared constants, types and helpers for the streaming
// light hash.
//   IV            : 8-byte initial value, H[i] starts at IV[i mod 8]
//   CHAR_*        : bounds of the accepted ASCII alphanumeric ranges
//   lh_state_e    : controller states
//   is_valid_char : 1 when a character lies in one of the accepted ranges
//   aes128_sbox   : AES forward S-box lookup
package light_hash_pkg;

  localparam logic [7:0] IV [8] = '{8'h34, 8'h55, 8'h0F, 8'h14,
                                    8'hAA, 8'h25, 8'hD4, 8'hE8};

  localparam logic [7:0] CHAR_DIGIT_LO = 8'h30;
  localparam logic [7:0] CHAR_DIGIT_HI = 8'h39;
  localparam logic [7:0] CHAR_UPPER_LO = 8'h41;
  localparam logic [7:0] CHAR_UPPER_HI = 8'h5A;
  localparam logic [7:0] CHAR_LOWER_LO = 8'h61;
  localparam logic [7:0] CHAR_LOWER_HI = 8'h7A;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    ROUND  = 2'd1,
    OUTPUT = 2'd2
  } lh_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] aes128_sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic is_valid_char(input logic [7:0] c);
    return ((c >= CHAR_DIGIT_LO) && (c <= CHAR_DIGIT_HI)) ||
           ((c >= CHAR_UPPER_LO) && (c <= CHAR_UPPER_HI)) ||
           ((c >= CHAR_LOWER_LO) && (c <= CHAR_LOWER_HI));
  endfunction

endpackage

// File: rtl/light_hash_round.sv
// light_hash_round: one combinational hash round on character c.
//   h_i [8N-1:0] : state before the round, byte i at h_i[8i+7:8i]
//   c_i [7:0]    : absorbed character
//   h_o [8N-1:0] : state after the round
module light_hash_round
  import light_hash_pkg::*;
#(
  parameter int DIGEST_BYTES = 8
) (
  input  logic [8*DIGEST_BYTES-1:0] h_i,
  input  logic [7:0]                c_i,
  output logic [8*DIGEST_BYTES-1:0] h_o
);

  logic [8*DIGEST_BYTES-1:0] h_tmp;
  logic [7:0]                t;

  // Bytes are updated in place and in order, so the last two bytes see the
  // freshly written H[0] and H[1] from this same round.
  always_comb begin
    h_tmp = h_i;
    t     = '0;
    for (int i = 0; i < DIGEST_BYTES; i++) begin
      t = h_tmp[8*((i+2)%DIGEST_BYTES) +: 8] ^ c_i;
      t = t << (i % 8);
      h_tmp[8*i +: 8] = aes128_sbox(t);
    end
  end

  assign h_o = h_tmp;

endmodule

// File: rtl/light_hash_stream.sv
// light_hash_stream: streaming light hash. Characters are absorbed one per
// handshake, each followed by ROUNDS rounds (ROUNDS_PER_CYCLE per clock);
// after the last character the digest is offered on a second handshake.
//   clk, rst_n            : clock, async active-low reset
//   ptxt_char/valid/last  : character input, ptxt_ready back-pressure
//   digest [8N-1:0]       : H[i] at digest[8i+7:8i], zero unless valid and ok
//   digest_valid/err      : digest offered; err = message had a bad char
//   digest_ready          : consumer accepts the digest
//
// state  | meaning
// ACCEPT | waiting for a character, ptxt_ready=1
// ROUND  | applying rounds to the registered character
// OUTPUT | digest presented, waiting for digest_ready
module light_hash_stream
  import light_hash_pkg::*;
#(
  parameter int DIGEST_BYTES     = 8,
  parameter int ROUNDS           = 32,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                ptxt_char,
  input  logic                      ptxt_valid,
  input  logic                      ptxt_last,
  output logic                      ptxt_ready,
  output logic [8*DIGEST_BYTES-1:0] digest,
  output logic                      digest_valid,
  output logic                      digest_err,
  input  logic                      digest_ready
);

  localparam int HW = 8 * DIGEST_BYTES;
  localparam int K  = ROUNDS / ROUNDS_PER_CYCLE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  if ((ROUNDS < 1) || (ROUNDS_PER_CYCLE < 1) || (DIGEST_BYTES < 3) ||
      ((ROUNDS % ROUNDS_PER_CYCLE) != 0)) begin : g_param_check
    $error("light_hash_stream: need DIGEST_BYTES>=3, ROUNDS>=1, ROUNDS a multiple of ROUNDS_PER_CYCLE");
  end

  lh_state_e         state_q;
  logic [HW-1:0]     h_q;
  logic [7:0]        c_q;
  logic              last_q;
  logic              err_q;
  logic [CW-1:0]     cnt_q;
  logic              ptxt_ready_q;
  logic              digest_valid_q;
  logic              digest_err_q;
  logic [HW-1:0]     iv_full;
  logic [HW-1:0]     h_rounds;

  for (genvar i = 0; i < DIGEST_BYTES; i++) begin : g_iv
    assign iv_full[8*i +: 8] = IV[i % 8];
  end

  // ROUNDS_PER_CYCLE rounds chained combinationally per clock.
  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_stage
    logic [HW-1:0] h_in;
    logic [HW-1:0] h_out;
    if (g == 0) begin : g_first
      assign h_in = h_q;
    end else begin : g_next
      assign h_in = g_stage[g-1].h_out;
    end
    light_hash_round #(
      .DIGEST_BYTES(DIGEST_BYTES)
    ) u_round (
      .h_i(h_in),
      .c_i(c_q),
      .h_o(h_out)
    );
  end

  assign h_rounds = g_stage[ROUNDS_PER_CYCLE-1].h_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ACCEPT;
      h_q            <= iv_full;
      c_q            <= '0;
      last_q         <= 1'b0;
      err_q          <= 1'b0;
      cnt_q          <= '0;
      ptxt_ready_q   <= 1'b1;
      digest_valid_q <= 1'b0;
      digest_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCEPT: begin
          if (ptxt_valid) begin
            c_q          <= ptxt_char;
            last_q       <= ptxt_last;
            cnt_q        <= '0;
            ptxt_ready_q <= 1'b0;
            state_q      <= ROUND;
            if (!is_valid_char(ptxt_char)) err_q <= 1'b1;
          end
        end
        ROUND: begin
          h_q <= h_rounds;
          if (cnt_q == CW'(K - 1)) begin
            cnt_q <= '0;
            if (last_q) begin
              state_q        <= OUTPUT;
              digest_valid_q <= 1'b1;
              digest_err_q   <= err_q;
            end else begin
              state_q      <= ACCEPT;
              ptxt_ready_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        OUTPUT: begin
          if (digest_ready) begin
            h_q            <= iv_full;
            err_q          <= 1'b0;
            state_q        <= ACCEPT;
            digest_valid_q <= 1'b0;
            digest_err_q   <= 1'b0;
            ptxt_ready_q   <= 1'b1;
          end
        end
        default: state_q <= ACCEPT;
      endcase
    end
  end

  assign ptxt_ready   = ptxt_ready_q;
  assign digest_valid = digest_valid_q;
  assign digest_err   = digest_err_q;
  // H does not change while in OUTPUT, so gating it keeps the digest stable.
  assign digest       = (digest_valid_q && !digest_err_q) ? h_q : '0;

endmodule

// File: tb/tb_light_hash_stream.sv
module tb_light_hash_stream;

  localparam int K = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ptxt_char;
  logic        ptxt_valid, ptxt_last, ptxt_ready;
  logic [63:0] digest;
  logic        digest_valid, digest_err, digest_ready;
  bit          sweep_go;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  light_hash_stream dut (
    .clk(clk), .rst_n(rst_n),
    .ptxt_char(ptxt_char), .ptxt_valid(ptxt_valid), .ptxt_last(ptxt_last),
    .ptxt_ready(ptxt_ready),
    .digest(digest), .digest_valid(digest_valid), .digest_err(digest_err),
    .digest_ready(digest_ready)
  );

  // ---------------- reference model ----------------
  logic [7:0] sbox_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int s);
    logic [15:0] w;
    w = {v, v} << s;
    return w[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic bit m_valid(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  function automatic logic [127:0] m_iv(input int n);
    logic [7:0]   ivb [8];
    logic [127:0] r;
    ivb = '{8'h34, 8'h55, 8'h0F, 8'h14, 8'hAA, 8'h25, 8'hD4, 8'hE8};
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = ivb[i % 8];
    return r;
  endfunction

  function automatic logic [127:0] m_round(input logic [127:0] h, input int n, input logic [7:0] c);
    logic [127:0] r;
    logic [7:0]   t;
    r = h;
    for (int i = 0; i < n; i++) begin
      t = r[8*((i+2)%n) +: 8] ^ c;
      t = t << (i % 8);
      r[8*i +: 8] = sbox_m[t];
    end
    return r;
  endfunction

  function automatic logic [127:0] m_absorb(input logic [127:0] h, input int n, input logic [7:0] c);
    logic [127:0] r;
    r = h;
    for (int k = 0; k < K; k++) r = m_round(r, n, c);
    return r;
  endfunction

  function automatic logic [127:0] m_hash_q(input logic [7:0] q[$], input int n, output bit err);
    logic [127:0] h;
    h = m_iv(n); err = 1'b0;
    foreach (q[j]) begin
      h = m_absorb(h, n, q[j]);
      if (!m_valid(q[j])) err = 1'b1;
    end
    return err ? 128'd0 : h;
  endfunction

  function automatic logic [127:0] m_hash_s(input string s, input int n, output bit err);
    logic [7:0] q[$];
    for (int j = 0; j < s.len(); j++) q.push_back(s[j]);
    return m_hash_q(q, n, err);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  logic [127:0] mh;
  bit           m_err, m_last, m_out;
  int           m_busy;
  int           dut_acc = 0;

  always @(negedge clk) begin
    logic er, ev, ee;
    logic [63:0] ed;
    if (!rst_n) begin
      mh = m_iv(8); m_err = 0; m_last = 0; m_out = 0; m_busy = 0;
      chk("rst_ptxt_ready", 128'(ptxt_ready), 128'(1));
      chk("rst_digest_valid", 128'(digest_valid), 128'(0));
      chk("rst_digest_err", 128'(digest_err), 128'(0));
      chk("rst_digest", 128'(digest), 128'(0));
    end else begin
      ev = (m_busy == 0) && m_out;
      er = (m_busy == 0) && !m_out;
      ee = ev && m_err;
      ed = (ev && !m_err) ? mh[63:0] : 64'd0;
      chk("cyc_ptxt_ready", 128'(ptxt_ready), 128'(er));
      chk("cyc_digest_valid", 128'(digest_valid), 128'(ev));
      chk("cyc_digest_err", 128'(digest_err), 128'(ee));
      chk("cyc_digest", 128'(digest), 128'(ed));
      if (ptxt_valid && ptxt_ready) dut_acc++;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0 && m_last) m_out = 1;
      end else if (er && ptxt_valid) begin
        mh = m_absorb(mh, 8, ptxt_char);
        if (!m_valid(ptxt_char)) m_err = 1;
        m_last = ptxt_last;
        m_busy = K;
      end else if (ev && digest_ready) begin
        m_out = 0; m_err = 0; m_last = 0; mh = m_iv(8);
      end
    end
  end

  // ---------------- ROUNDS_PER_CYCLE sweep instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int RPC = (g == 0) ? 1 : ((g == 1) ? 4 : 32);
    logic [7:0]  ch;
    logic        v, l, rdy, dv, de, dr;
    logic [95:0] dg;
    logic [95:0] cap;
    logic        cap_err;
    int          lat0, lat1;
    bit          done;

    light_hash_stream #(.DIGEST_BYTES(12), .ROUNDS(32), .ROUNDS_PER_CYCLE(RPC)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ptxt_char(ch), .ptxt_valid(v), .ptxt_last(l), .ptxt_ready(rdy),
      .digest(dg), .digest_valid(dv), .digest_err(de), .digest_ready(dr)
    );

    initial begin
      int n;
      int t0;
      v = 0; ch = 0; l = 0; dr = 0; done = 0; lat0 = -1; lat1 = -1; cap = '0; cap_err = 1'b1;
      wait (sweep_go);
      @(posedge clk); #1;
      ch = "Z"; l = 0; v = 1;
      n = 0;
      while (n < 100) begin @(negedge clk); n++; if (rdy) break; end
      t0 = cyc + 1;
      @(posedge clk); #1;
      ch = "9"; l = 1;
      n = 0;
      while (n < 100) begin @(negedge clk); n++; if (rdy) break; end
      lat0 = cyc - t0;
      t0 = cyc + 1;
      @(posedge clk); #1;
      v = 0;
      n = 0;
      while (n < 100) begin @(negedge clk); n++; if (dv) break; end
      lat1 = cyc - t0;
      cap = dg; cap_err = de;
      @(posedge clk); #1 dr = 1;
      @(posedge clk); #1 dr = 0;
      done = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c, input bit last, input bit keep, output int t_acc);
    int n;
    bit ok;
    ptxt_char = c; ptxt_last = last; ptxt_valid = 1;
    n = 0; ok = 0;
    while (n < 200 && !ok) begin
      @(negedge clk);
      n++;
      if (ptxt_ready) ok = 1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: ptxt_ready still %0b after %0d cycles, required 1", ptxt_ready, n);
    end
    t_acc = cyc + 1;
    @(posedge clk); #1;
    if (!keep) ptxt_valid = 0;
  endtask

  task automatic wait_digest(input int hold, output int t_seen, output logic [63:0] d, output bit e);
    int n;
    bit ok;
    n = 0; ok = 0;
    while (n < 200 && !ok) begin
      @(negedge clk);
      n++;
      if (digest_valid) ok = 1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL digest_timeout: digest_valid still %0b after %0d cycles, required 1", digest_valid, n);
    end
    t_seen = cyc; d = digest; e = digest_err;
    @(posedge clk);
    repeat (hold) @(posedge clk);
    #1 digest_ready = 1;
    @(posedge clk); #1 digest_ready = 0;
  endtask

  task automatic check_reset_now(input string tag);
    chk({tag, "_ptxt_ready"}, 128'(ptxt_ready), 128'(1));
    chk({tag, "_digest_valid"}, 128'(digest_valid), 128'(0));
    chk({tag, "_digest_err"}, 128'(digest_err), 128'(0));
    chk({tag, "_digest"}, 128'(digest), 128'(0));
    chk({tag, "_H"}, 128'(dut.h_q), m_iv(8));
  endtask

  initial begin
    logic [127:0] r, ex, exp_a;
    logic [63:0]  d;
    bit           e, ee;
    int           t0, ts, a0, len, n;
    int           tacc [6];
    string        s, alnum;
    logic [7:0]   q[$];
    logic [7:0]   c;

    rst_n = 0; ptxt_char = 0; ptxt_valid = 0; ptxt_last = 0; digest_ready = 0; sweep_go = 0;
    alnum = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz";
    build_sbox();

    // hand-computed pins on the model itself
    chk("pin_sbox_00", 128'(sbox_m[8'h00]), 128'(8'h63));
    chk("pin_sbox_53", 128'(sbox_m[8'h53]), 128'(8'hED));
    chk("pin_sbox_ff", 128'(sbox_m[8'hFF]), 128'(8'h16));
    r = m_round(m_iv(8), 8, 8'h61);
    chk("pin_round_h0", 128'(r[7:0]), 128'(8'h9F));
    chk("pin_round_h1", 128'(r[15:8]), 128'(8'h87));
    chk("pin_round_h2", 128'(r[23:16]), 128'(8'h71));
    chk("pin_round_h6", 128'(r[55:48]), 128'(8'hCD));
    chk("pin_round_h7", 128'(r[63:56]), 128'(8'h63));

    // test 1: reset and idle
    repeat (3) @(negedge clk);
    #1 check_reset_now("reset");
    rst_n = 1;
    idle(3);
    check_reset_now("idle");

    // test 2: "a", latency and held digest
    exp_a = m_hash_s("a", 8, ee);
    send_char(8'h61, 1, 0, t0);
    wait_digest(10, ts, d, e);
    chk("a_latency", 128'(ts - t0), 128'(32));
    chk("a_digest", 128'(d), exp_a);
    chk("a_err", 128'(e), 128'(0));

    // test 3: "Hash42" with ptxt_valid held high, twice
    s = "Hash42";
    ex = m_hash_s(s, 8, ee);
    for (int rep = 0; rep < 2; rep++) begin
      a0 = dut_acc;
      for (int i = 0; i < 6; i++) send_char(s[i], i == 5, i != 5, tacc[i]);
      wait_digest(0, ts, d, e);
      chk("h42_accepts", 128'(dut_acc - a0), 128'(6));
      for (int i = 1; i < 6; i++) chk("h42_spacing", 128'(tacc[i] - tacc[i-1]), 128'(33));
      chk("h42_latency", 128'(ts - tacc[5]), 128'(32));
      chk("h42_digest", 128'(d), ex);
      chk("h42_err", 128'(e), 128'(0));
      idle(1);
    end

    // test 4: invalid character, then a clean message
    s = "ab#c";
    for (int i = 0; i < 4; i++) send_char(s[i], i == 3, 0, t0);
    wait_digest(2, ts, d, e);
    chk("inv_latency", 128'(ts - t0), 128'(32));
    chk("inv_digest", 128'(d), 128'(0));
    chk("inv_err", 128'(e), 128'(1));
    s = "abc";
    ex = m_hash_s(s, 8, ee);
    for (int i = 0; i < 3; i++) send_char(s[i], i == 2, 0, t0);
    wait_digest(0, ts, d, e);
    chk("abc_digest", 128'(d), ex);
    chk("abc_err", 128'(e), 128'(0));

    // randomized messages
    for (int m = 0; m < 12; m++) begin
      q.delete();
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 7) == 0) c = 8'($urandom_range(0, 255));
        else c = alnum[$urandom_range(0, 61)];
        q.push_back(c);
      end
      ex = m_hash_q(q, 8, ee);
      for (int j = 0; j < len; j++) begin
        idle($urandom_range(0, 2));
        send_char(q[j], j == len - 1, 0, t0);
      end
      wait_digest($urandom_range(0, 4), ts, d, e);
      chk("rand_digest", 128'(d), ex);
      chk("rand_err", 128'(e), 128'(ee));
    end

    // test 5: ROUNDS_PER_CYCLE sweep, DIGEST_BYTES=12
    sweep_go = 1;
    n = 0;
    while (n < 600 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done)) begin
      @(negedge clk); n++;
    end
    chk("sweep_done", 128'({g_sw[0].done, g_sw[1].done, g_sw[2].done}), 128'(3'b111));
    ex = m_hash_s("Z9", 12, ee);
    chk("sweep1_digest", 128'(g_sw[0].cap), ex);
    chk("sweep4_digest", 128'(g_sw[1].cap), ex);
    chk("sweep32_digest", 128'(g_sw[2].cap), ex);
    chk("sweep_err", 128'({g_sw[0].cap_err, g_sw[1].cap_err, g_sw[2].cap_err}), 128'(0));
    chk("sweep1_lat0", 128'(g_sw[0].lat0), 128'(32));
    chk("sweep1_lat1", 128'(g_sw[0].lat1), 128'(32));
    chk("sweep4_lat0", 128'(g_sw[1].lat0), 128'(8));
    chk("sweep4_lat1", 128'(g_sw[1].lat1), 128'(8));
    chk("sweep32_lat0", 128'(g_sw[2].lat0), 128'(1));
    chk("sweep32_lat1", 128'(g_sw[2].lat1), 128'(1));
    @(posedge clk); #1;

    // test 6: reset during ROUND of the 2nd character
    send_char(8'h61, 0, 0, t0);
    send_char(8'h62, 0, 0, t0);
    idle(5);
    @(negedge clk); #2 rst_n = 0;
    #1 check_reset_now("rst_round");
    @(negedge clk); #1 rst_n = 1;
    idle(1);

    // reset during OUTPUT
    send_char(8'h61, 1, 0, t0);
    n = 0;
    while (n < 200 && !digest_valid) begin @(negedge clk); n++; end
    chk("pre_rst_valid", 128'(digest_valid), 128'(1));
    #2 rst_n = 0;
    #1 check_reset_now("rst_output");
    @(negedge clk); #1 rst_n = 1;
    idle(1);

    send_char(8'h61, 1, 0, t0);
    wait_digest(1, ts, d, e);
    chk("post_rst_a_digest", 128'(d), exp_a);
    chk("post_rst_a_err", 128'(e), 128'(0));

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/light_hash_stream.md
Name: light_hash_stream

Overview:
- Multi-character streaming successor of the single-character AES-S-box light hash.
- Absorbs a message of ASCII alphanumeric characters one character at a time over a valid/ready handshake, then presents a parametrised-width digest over a second valid/ready handshake.
- Rounds are iterated over multiple cycles, with a configurable number of rounds unrolled per cycle.
- Sits between the character source (UART/testbench front end) and the digest consumer.

Parameters:
- DIGEST_BYTES, 8: number of 8-bit state bytes H[0..N-1]; must be >= 3.
- ROUNDS, 32: rounds applied per absorbed character; must be >= 1.
- ROUNDS_PER_CYCLE, 1: rounds computed per clock; ROUNDS % ROUNDS_PER_CYCLE == 0 (elaboration-time assertion).

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- ptxt_char, input, 8: message character.
- ptxt_valid, input, 1: ptxt_char and ptxt_last are valid.
- ptxt_last, input, 1: this character ends the message.
- ptxt_ready, output, 1: block can accept a character.
- digest, output, 8*DIGEST_BYTES: digest[8i+7:8i] = H[i].
- digest_valid, output, 1: digest and digest_err are valid.
- digest_err, output, 1: the message contained at least one invalid character.
- digest_ready, input, 1: consumer accepts the digest.

Behaviour:
- Reset (async, rst_n=0):
  - State = ACCEPT; H[i] = IV[i mod 8], with IV[0..7] = 34,55,0F,14,AA,25,D4,E8 (hex).
  - Round counter = 0, err_sticky = 0, last flag = 0.
  - Outputs: ptxt_ready=1, digest_valid=0, digest_err=0, digest=0.
- Valid characters: 0x30-0x39, 0x41-0x5A, 0x61-0x7A. Any other value is invalid.
- One round on character c:
  - For i = 0..N-1 in order: H[i] = SBOX( ((H[(i+2) mod N] ^ c) << (i mod 8)) [7:0] ).
  - The update is in place and sequential: H[N-2] and H[N-1] use the already-updated H[0] and H[1] from the same round.
  - The left shift truncates to 8 bits.
- FSM:
  - ACCEPT:
    - ptxt_ready=1.
    - On ptxt_valid&&ptxt_ready: register c and last, set err_sticky if c is invalid, counter=0, go to ROUND.
  - ROUND:
    - ptxt_ready=0.
    - Each cycle applies ROUNDS_PER_CYCLE chained rounds to H and increments the counter.
    - After the edge that completes ROUNDS total rounds: if last, go to OUTPUT; else go to ACCEPT.
  - OUTPUT:
    - digest_valid=1.
    - digest = H if err_sticky=0; digest = 0 with digest_err=1 if err_sticky=1.
    - digest and digest_err are held stable until digest_ready.
    - On digest_valid&&digest_ready: reload H=IV, clear err_sticky, go to ACCEPT.
- Latency:
  - Let K = ROUNDS/ROUNDS_PER_CYCLE.
  - Accept edge t → ptxt_ready high again (or digest_valid high for the last character) in the cycle following edge t+K.
  - Throughput is one character per K+1 cycles.
- Invalid characters are still absorbed with full round timing, so timing is data-independent.
- ptxt_valid outside ACCEPT is ignored. The source must hold its data until ready.
- digest_ready outside OUTPUT is ignored.
- A single-character message is a character with ptxt_last=1. The empty message is not representable.
- Reset asserted mid-message or mid-output aborts the operation: immediate return to reset values, no partial digest.
- Back-to-back messages: a new message may be accepted in the cycle following the digest handshake.

Decomposition:
- Package light_hash_pkg:
  - IV constant array (8 bytes).
  - Character-range constants.
  - FSM state enum {ACCEPT, ROUND, OUTPUT}.
  - Character-validity function.
  - Uses the shared aes128_sbox function.
- Sub-module light_hash_round:
  - Combinational single round (parameter DIGEST_BYTES; inputs H and c; output H').
  - The top instantiates ROUNDS_PER_CYCLE copies chained in a generate loop.

Test Plan:
1. Reset, then idle → ptxt_ready=1, digest_valid=0, digest=0; after rst_n rises, H equals IV repeated (34,55,0F,14,AA,25,D4,E8).
2. Defaults; message "a" with last=1 → digest_valid rises exactly 32 cycles after the accept edge; digest equals the golden software model; digest_err=0; digest held stable with digest_ready=0 for 10 cycles.
3. Message "Hash42", one character per handshake, with ptxt_valid left high throughout → exactly 6 accepts, each spaced 33 cycles apart; digest matches the model; sending the same message again gives an identical digest (IV reload verified).
4. Message "ab#c" (0x23 invalid) → digest_valid after the 4th character's rounds, digest=0, digest_err=1; the following message "abc" gives digest_err=0 and the model digest.
5. Sweep: DIGEST_BYTES=12, ROUNDS=32, ROUNDS_PER_CYCLE ∈ {1,4,32} on message "Z9" → all three digests are identical and match the model; per-character latency is 32, 8 and 1 cycles respectively.
6. rst_n pulsed low during ROUND of the 2nd character, and separately during OUTPUT → outputs take reset values asynchronously; message "a" sent afterwards matches the test-2 digest.
